// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station bank.
// Struct field widths are fixed here. Any width override on the bank must
// match these values.
package branch_rs_pkg;

  localparam int RS_DATA_W = 32;
  localparam int RS_ROB_W  = 3;
  localparam int RS_CTRL_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [RS_ROB_W-1:0]  rob;
    logic [RS_DATA_W-1:0] result;
  } cdb_t;

  typedef struct packed {
    logic                 busy;
    logic                 rdy1;
    logic                 rdy2;
    logic [RS_ROB_W-1:0]  tag1;
    logic [RS_ROB_W-1:0]  tag2;
    logic [RS_DATA_W-1:0] val1;
    logic [RS_DATA_W-1:0] val2;
    logic [RS_ROB_W-1:0]  robInstr;
    logic [RS_CTRL_W-1:0] ctrl;
    logic [RS_DATA_W-1:0] predPC;
    logic [RS_DATA_W-1:0] target;
    logic [RS_DATA_W-1:0] seqPC;
  } branch_entry_t;

endpackage

// File: rtl/branch_rs_slot.sv
// One reservation station entry.
// - Accepts a dispatch write and applies write-time wake-up from the CDBs.
// - Snoops the CDBs so that waiting operands become ready.
// - Reports eligibility and drives source operands with same-cycle forwarding.
module branch_rs_slot
  import branch_rs_pkg::*;
#(
  parameter int NCDB = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_en,
  input  branch_entry_t        wr_entry,
  input  cdb_t                 cdb [NCDB],
  input  logic                 issue,
  output logic                 busy,
  output logic                 eligible,
  output logic [RS_ROB_W-1:0]  rob,
  output logic [RS_CTRL_W-1:0] ctrl,
  output logic [RS_DATA_W-1:0] pred_pc,
  output logic [RS_DATA_W-1:0] target,
  output logic [RS_DATA_W-1:0] seq_pc,
  output logic [RS_DATA_W-1:0] src1,
  output logic [RS_DATA_W-1:0] src2
);

  branch_entry_t        e;
  branch_entry_t        wr_woken;
  logic                 hit1, hit2, whit1, whit2;
  logic [RS_DATA_W-1:0] fwd1, fwd2, wfwd1, wfwd2;

  // Returns {hit, result}.
  // Buses are scanned from high to low index, so the lowest matching bus wins.
  function automatic logic [RS_DATA_W:0] cdb_lookup(input cdb_t bus [NCDB],
                                                    input logic [RS_ROB_W-1:0] tag);
    logic [RS_DATA_W:0] r;
    r = '0;
    for (int i = NCDB - 1; i >= 0; i--) begin
      if (bus[i].valid && bus[i].rob == tag) r = {1'b1, bus[i].result};
    end
    return r;
  endfunction

  // Tag compares for the stored operands and for the incoming dispatch operands.
  always_comb begin
    {hit1, fwd1}   = cdb_lookup(cdb, e.tag1);
    {hit2, fwd2}   = cdb_lookup(cdb, e.tag2);
    {whit1, wfwd1} = cdb_lookup(cdb, wr_entry.tag1);
    {whit2, wfwd2} = cdb_lookup(cdb, wr_entry.tag2);
  end

  // Dispatch record with the write-time wake-up applied.
  always_comb begin
    wr_woken      = wr_entry;
    wr_woken.busy = 1'b1;
    if (!wr_entry.rdy1 && whit1) begin
      wr_woken.rdy1 = 1'b1;
      wr_woken.val1 = wfwd1;
    end
    if (!wr_entry.rdy2 && whit2) begin
      wr_woken.rdy2 = 1'b1;
      wr_woken.val2 = wfwd2;
    end
  end

  // Entry state.
  // Priority order is clear, then write, then issue and wake-up.
  // The bank only writes free slots and only issues busy ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= '0;
    end else if (clear) begin
      e <= '0;
    end else if (wr_en) begin
      e <= wr_woken;
    end else if (e.busy) begin
      if (issue) e.busy <= 1'b0;
      if (!e.rdy1 && hit1) begin
        e.rdy1 <= 1'b1;
        e.val1 <= fwd1;
      end
      if (!e.rdy2 && hit2) begin
        e.rdy2 <= 1'b1;
        e.val2 <= fwd2;
      end
    end
  end

  // Eligibility and forwarded sources.
  // Forwarding applies only to a live, waiting operand.
  always_comb begin
    eligible = e.busy && (e.rdy1 || hit1) && (e.rdy2 || hit2);
    src1     = (e.busy && !e.rdy1 && hit1) ? fwd1 : e.val1;
    src2     = (e.busy && !e.rdy2 && hit2) ? fwd2 : e.val2;
  end

  assign busy    = e.busy;
  assign rob     = e.robInstr;
  assign ctrl    = e.ctrl;
  assign pred_pc = e.predPC;
  assign target  = e.target;
  assign seq_pc  = e.seqPC;

endmodule

// File: rtl/branch_rs_bank.sv
// Multi-entry branch reservation station.
// - Holds DEPTH slots filled through a lowest-free-index allocator.
// - An age matrix selects the oldest eligible entry.
// - One issue per cycle goes to the branch ALU through a valid/ready handshake.
module branch_rs_bank
  import branch_rs_pkg::*;
#(
  parameter int DATA_W = RS_DATA_W,
  parameter int ROB_W  = RS_ROB_W,
  parameter int CTRL_W = RS_CTRL_W,
  parameter int DEPTH  = 4,
  parameter int NCDB   = 2
) (
  input  logic                     clk,
  input  logic                     globalReset,
  input  logic                     clear,
  input  logic                     writeReq,
  input  logic                     ready1,
  input  logic                     ready2,
  input  logic signed [DATA_W-1:0] value1,
  input  logic signed [DATA_W-1:0] value2,
  input  logic [ROB_W-1:0]         rob1,
  input  logic [ROB_W-1:0]         rob2,
  input  logic [ROB_W-1:0]         robInstr,
  input  logic [CTRL_W-1:0]        branchControl,
  input  logic [DATA_W-1:0]        predictedPC,
  input  logic [DATA_W-1:0]        address,
  input  logic [DATA_W-1:0]        seqPC,
  input  logic [NCDB-1:0]          cdbValid,
  input  logic [NCDB*ROB_W-1:0]    cdbRob,
  input  logic [NCDB*DATA_W-1:0]   cdbResult,
  output logic                     full,
  output logic                     issueValid,
  input  logic                     issueReady,
  output logic [ROB_W-1:0]         instrRob,
  output logic [CTRL_W-1:0]        instrInfo,
  output logic signed [DATA_W-1:0] src1,
  output logic signed [DATA_W-1:0] src2,
  output logic [DATA_W-1:0]        predictedAddress,
  output logic [DATA_W-1:0]        targetAddress,
  output logic [DATA_W-1:0]        branchResult
);

  localparam int IDX_W = $clog2(DEPTH);

  cdb_t                       cdb [NCDB];
  branch_entry_t              wr_entry;
  logic [DEPTH-1:0]           busy, elig, wr_en, sel, issue_en;
  // older[i][j] = 1 means entry i was allocated before entry j.
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [IDX_W-1:0]           alloc_idx, sel_idx;
  logic [RS_ROB_W-1:0]        s_rob  [DEPTH];
  logic [RS_CTRL_W-1:0]       s_ctrl [DEPTH];
  logic [RS_DATA_W-1:0]       s_pred [DEPTH];
  logic [RS_DATA_W-1:0]       s_tgt  [DEPTH];
  logic [RS_DATA_W-1:0]       s_seq  [DEPTH];
  logic [RS_DATA_W-1:0]       s_src1 [DEPTH];
  logic [RS_DATA_W-1:0]       s_src2 [DEPTH];

  // Unpack the flat CDB ports into one record per bus.
  always_comb begin
    for (int i = 0; i < NCDB; i++) begin
      cdb[i].valid  = cdbValid[i];
      cdb[i].rob    = cdbRob[i*ROB_W +: ROB_W];
      cdb[i].result = cdbResult[i*DATA_W +: DATA_W];
    end
  end

  // Assemble the dispatch record that is offered to every slot.
  always_comb begin
    wr_entry          = '0;
    wr_entry.busy     = 1'b1;
    wr_entry.rdy1     = ready1;
    wr_entry.rdy2     = ready2;
    wr_entry.tag1     = rob1;
    wr_entry.tag2     = rob2;
    wr_entry.val1     = value1;
    wr_entry.val2     = value2;
    wr_entry.robInstr = robInstr;
    wr_entry.ctrl     = branchControl;
    wr_entry.predPC   = predictedPC;
    wr_entry.target   = address;
    wr_entry.seqPC    = seqPC;
  end

  assign full = &busy;

  // Lowest-index free slot. This uses busy as it stands at the start of the cycle.
  always_comb begin
    alloc_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!busy[k]) alloc_idx = IDX_W'(k);
    end
  end

  // Write enables go only to the allocated slot. A write while full is dropped.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      wr_en[k] = writeReq && !full && (alloc_idx == IDX_W'(k));
    end
  end

  // Age matrix. A newly allocated entry becomes younger than every other entry.
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      older <= '0;
    end else if (clear) begin
      older <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_en[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older[k][j] <= 1'b0;
            older[j][k] <= (j != k);
          end
        end
      end
    end
  end

  // Oldest-eligible select. An entry is picked when no other eligible entry is older.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && older[j][i]) sel[i] = 1'b0;
      end
    end
  end

  // One-hot to index. With nothing selected the index falls back to entry 0.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel[k]) sel_idx = IDX_W'(k);
    end
  end

  assign issueValid = |elig;
  assign issue_en   = sel & {DEPTH{issueReady}};

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    branch_rs_slot #(.NCDB(NCDB)) u_slot (
      .clk      (clk),
      .rst      (globalReset),
      .clear    (clear),
      .wr_en    (wr_en[k]),
      .wr_entry (wr_entry),
      .cdb      (cdb),
      .issue    (issue_en[k]),
      .busy     (busy[k]),
      .eligible (elig[k]),
      .rob      (s_rob[k]),
      .ctrl     (s_ctrl[k]),
      .pred_pc  (s_pred[k]),
      .target   (s_tgt[k]),
      .seq_pc   (s_seq[k]),
      .src1     (s_src1[k]),
      .src2     (s_src2[k])
    );
  end

  assign instrRob         = s_rob[sel_idx];
  assign instrInfo        = s_ctrl[sel_idx];
  assign src1             = s_src1[sel_idx];
  assign src2             = s_src2[sel_idx];
  assign predictedAddress = s_pred[sel_idx];
  assign targetAddress    = s_tgt[sel_idx];
  assign branchResult     = s_seq[sel_idx];

endmodule

// File: tb/tb_branch_rs_bank.sv
// Directed bench for branch_rs_bank.
// A vector table covers dispatch, wake-up and age order.
// Hand-written sequences cover backpressure, flush and asynchronous reset.
module tb_branch_rs_bank;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 3;
  localparam int CTRL_W = 8;
  localparam int DEPTH  = 4;
  localparam int NCDB   = 2;

  logic                     clk = 1'b0;
  logic                     globalReset, clear, writeReq, ready1, ready2;
  logic signed [DATA_W-1:0] value1, value2;
  logic [ROB_W-1:0]         rob1, rob2, robInstr;
  logic [CTRL_W-1:0]        branchControl;
  logic [DATA_W-1:0]        predictedPC, address, seqPC;
  logic [NCDB-1:0]          cdbValid;
  logic [NCDB*ROB_W-1:0]    cdbRob;
  logic [NCDB*DATA_W-1:0]   cdbResult;
  logic                     full, issueValid, issueReady;
  logic [ROB_W-1:0]         instrRob;
  logic [CTRL_W-1:0]        instrInfo;
  logic signed [DATA_W-1:0] src1, src2;
  logic [DATA_W-1:0]        predictedAddress, targetAddress, branchResult;

  branch_rs_bank #(.DATA_W(DATA_W), .ROB_W(ROB_W), .CTRL_W(CTRL_W),
                   .DEPTH(DEPTH), .NCDB(NCDB)) dut (
    .clk(clk), .globalReset(globalReset), .clear(clear), .writeReq(writeReq),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
    .rob1(rob1), .rob2(rob2), .robInstr(robInstr), .branchControl(branchControl),
    .predictedPC(predictedPC), .address(address), .seqPC(seqPC),
    .cdbValid(cdbValid), .cdbRob(cdbRob), .cdbResult(cdbResult),
    .full(full), .issueValid(issueValid), .issueReady(issueReady),
    .instrRob(instrRob), .instrInfo(instrInfo), .src1(src1), .src2(src2),
    .predictedAddress(predictedAddress), .targetAddress(targetAddress),
    .branchResult(branchResult)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; writeReq = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
    value1 = '0; value2 = '0; rob1 = '0; rob2 = '0; robInstr = '0;
    branchControl = '0; predictedPC = '0; address = '0; seqPC = '0;
    cdbValid = '0; cdbRob = '0; cdbResult = '0; issueReady = 1'b0;
  endtask

  // Ready-operand dispatch with address fields derived from the rob tag.
  task automatic put(input logic [2:0] rob, input logic [31:0] v1);
    writeReq = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    value1 = v1; value2 = v1 + 32'd1; robInstr = rob;
    branchControl = {5'b10100, rob};
    predictedPC = 32'h1000 + {29'b0, rob};
    address     = 32'h2000 + {29'b0, rob};
    seqPC       = 32'h3000 + {29'b0, rob};
  endtask

  typedef struct {
    logic        wr, rd1, rd2;
    logic [31:0] v1, v2;
    logic [2:0]  t1, t2, rob;
    logic        ir;
    logic [1:0]  cv;
    logic [2:0]  cr0, cr1;
    logic [31:0] cres0, cres1;
    logic        e_full, e_iv;
    logic [2:0]  e_rob;
    logic [31:0] e_s1, e_s2;
  } vec_t;

  vec_t vecs [15];
  logic [2:0] drain_order [4];

  initial begin
    // wr rd1 rd2 v1 v2 t1 t2 rob ir cv cr0 cr1 cres0 cres1 | full iv rob s1 s2
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'd10, 32'hFFFF_FFFD, 3'd0, 3'd0, 3'd5, 1'b1, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b1, 3'd5, 32'd10, 32'hFFFF_FFFD};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'd0, 32'd7, 3'd2, 3'd0, 3'd4, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'b10, 3'd0, 3'd2, 32'h0, 32'h1234,
                 1'b0, 1'b1, 3'd4, 32'h1234, 32'd7};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b1, 3'd4, 32'h1234, 32'd7};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd0, 32'd1, 3'd3, 3'd0, 3'd6, 1'b0, 2'b11, 3'd3, 3'd3, 32'h11, 32'h22,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b1, 3'd6, 32'h11, 32'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 3'd7, 3'd0, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 3'd7, 3'd0, 3'd2, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 3'd7, 3'd0, 3'd3, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b01, 3'd7, 3'd0, 32'h77, 32'h0,
                 1'b0, 1'b1, 3'd1, 32'h77, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b1, 3'd2, 32'h77, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b1, 3'd3, 32'h77, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 3'd0, 32'h0, 32'h0};
    drain_order = '{3'd2, 3'd3, 3'd4, 3'd6};

    // Reset state
    idle_inputs();
    globalReset = 1'b1;
    #1;
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_issueValid", {31'b0, issueValid}, 32'd0);
    check("rst_src1", src1, 32'd0);
    check("rst_instrRob", {29'b0, instrRob}, 32'd0);
    tick();
    tick();
    globalReset = 1'b0;

    // Table-driven vectors, one clock cycle each
    for (int i = 0; i < 15; i++) begin
      writeReq = vecs[i].wr; ready1 = vecs[i].rd1; ready2 = vecs[i].rd2;
      value1 = vecs[i].v1; value2 = vecs[i].v2;
      rob1 = vecs[i].t1; rob2 = vecs[i].t2; robInstr = vecs[i].rob;
      issueReady = vecs[i].ir; cdbValid = vecs[i].cv;
      cdbRob = {vecs[i].cr1, vecs[i].cr0};
      cdbResult = {vecs[i].cres1, vecs[i].cres0};
      #3;
      check($sformatf("vec%0d_full", i), {31'b0, full}, {31'b0, vecs[i].e_full});
      check($sformatf("vec%0d_issueValid", i), {31'b0, issueValid}, {31'b0, vecs[i].e_iv});
      if (vecs[i].e_iv) begin
        check($sformatf("vec%0d_instrRob", i), {29'b0, instrRob}, {29'b0, vecs[i].e_rob});
        check($sformatf("vec%0d_src1", i), src1, vecs[i].e_s1);
        check($sformatf("vec%0d_src2", i), src2, vecs[i].e_s2);
      end
      tick();
    end
    idle_inputs();

    // Fill to full with no issue, then apply backpressure
    for (int r = 1; r <= 4; r++) begin
      put(3'(r), 32'h100 + 32'(r));
      tick();
    end
    idle_inputs();
    #2;
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_issueValid", {31'b0, issueValid}, 32'd1);
    check("fill_instrRob", {29'b0, instrRob}, 32'd1);
    check("fill_src1", src1, 32'h101);
    check("fill_src2", src2, 32'h102);
    check("fill_instrInfo", {24'b0, instrInfo}, 32'hA1);
    check("fill_predictedAddress", predictedAddress, 32'h1001);
    check("fill_targetAddress", targetAddress, 32'h2001);
    check("fill_branchResult", branchResult, 32'h3001);
    put(3'd7, 32'h107);
    tick();
    idle_inputs();
    #2;
    check("ovf_full", {31'b0, full}, 32'd1);
    check("ovf_instrRob", {29'b0, instrRob}, 32'd1);
    issueReady = 1'b1;
    #1;
    check("bp_issue_rob", {29'b0, instrRob}, 32'd1);
    tick();
    issueReady = 1'b0;
    #2;
    check("bp_full_after_issue", {31'b0, full}, 32'd0);
    put(3'd6, 32'h106);
    tick();
    idle_inputs();
    #2;
    check("refill_full", {31'b0, full}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      issueReady = 1'b1;
      #2;
      check($sformatf("drain%0d_issueValid", k), {31'b0, issueValid}, 32'd1);
      check($sformatf("drain%0d_instrRob", k), {29'b0, instrRob}, {29'b0, drain_order[k]});
      tick();
    end
    issueReady = 1'b0;
    #2;
    check("drained_issueValid", {31'b0, issueValid}, 32'd0);
    check("drained_full", {31'b0, full}, 32'd0);
    check("reused_slot0_rob", {29'b0, instrRob}, 32'd6);
    check("reused_slot0_src1", src1, 32'h106);

    // Flush with two entries busy and a write in the same cycle
    put(3'd2, 32'h202);
    tick();
    put(3'd3, 32'h303);
    tick();
    put(3'd4, 32'h404);
    clear = 1'b1;
    tick();
    idle_inputs();
    #2;
    check("flush_full", {31'b0, full}, 32'd0);
    check("flush_issueValid", {31'b0, issueValid}, 32'd0);
    check("flush_instrRob", {29'b0, instrRob}, 32'd0);
    check("flush_src1", src1, 32'd0);
    check("flush_src2", src2, 32'd0);
    check("flush_instrInfo", {24'b0, instrInfo}, 32'd0);
    check("flush_predictedAddress", predictedAddress, 32'd0);
    tick();
    #2;
    check("flush_write_dropped", {31'b0, issueValid}, 32'd0);

    // Asynchronous reset between clock edges with three entries busy
    for (int r = 1; r <= 3; r++) begin
      put(3'(r), 32'h50 + 32'(r));
      tick();
    end
    idle_inputs();
    #2;
    check("pre_areset_issueValid", {31'b0, issueValid}, 32'd1);
    globalReset = 1'b1;
    #1;
    check("areset_full", {31'b0, full}, 32'd0);
    check("areset_issueValid", {31'b0, issueValid}, 32'd0);
    check("areset_instrRob", {29'b0, instrRob}, 32'd0);
    check("areset_src1", src1, 32'd0);
    check("areset_src2", src2, 32'd0);
    check("areset_instrInfo", {24'b0, instrInfo}, 32'd0);
    check("areset_predictedAddress", predictedAddress, 32'd0);
    check("areset_targetAddress", targetAddress, 32'd0);
    check("areset_branchResult", branchResult, 32'd0);
    #2;
    globalReset = 1'b0;
    tick();
    #2;
    check("post_areset_issueValid", {31'b0, issueValid}, 32'd0);
    check("post_areset_full", {31'b0, full}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
